// File: rtl/mem_bank_loader.sv
// Streams one frame of ROWS*COLS bytes into a 2-D bank in row-major order, one write per accepted byte.
// Build option: MEM_BANK_LOADER_CSUM_EN adds a trailing checksum byte checked against the frame sum.
module mem_bank_loader #(
    parameter int DW   = 8,
    parameter int ROWS = 4,
    parameter int COLS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [DW-1:0]           s_data,
    output logic                    s_ready,
    input  logic                    bank_rdy,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] addr_i,
    output logic [$clog2(COLS)-1:0] addr_j,
    output logic [DW-1:0]           wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    csum_err
);

    localparam int IW = $clog2(ROWS);
    localparam int JW = $clog2(COLS);
    localparam logic [IW-1:0] I_LAST = IW'(ROWS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(COLS - 1);
    localparam logic [IW-1:0] I_ONE  = IW'(1);
    localparam logic [JW-1:0] J_ONE  = JW'(1);

`ifdef MEM_BANK_LOADER_CSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CSUM = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t          state_reg, state_next;
    logic [IW-1:0]   i_reg;
    logic [JW-1:0]   j_reg;
    logic            wr_en_reg;
    logic [IW-1:0]   addr_i_reg;
    logic [JW-1:0]   addr_j_reg;
    logic [DW-1:0]   wr_data_reg;
    logic            start_ok;
    logic            load_xfer;
    logic            last_cell;

    assign last_cell = (i_reg == I_LAST) && (j_reg == J_LAST);
    assign start_ok  = (state_reg == IDLE) && start && !abort;
    // A transfer in the abort cycle is dropped entirely: no write, no counter or sum update.
    assign load_xfer = (state_reg == LOAD) && s_valid && s_ready && !abort;

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                s_ready = bank_rdy;
                if (s_valid && bank_rdy && last_cell) begin
`ifdef MEM_BANK_LOADER_CSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef MEM_BANK_LOADER_CSUM_EN
            CSUM: begin
                s_ready = 1'b1;
                if (s_valid) state_next = DONE;
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            wr_en_reg   <= 1'b0;
            addr_i_reg  <= '0;
            addr_j_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= load_xfer;
            if (start_ok) begin
                i_reg <= '0;
                j_reg <= '0;
            end else if (load_xfer) begin
                addr_i_reg  <= i_reg;
                addr_j_reg  <= j_reg;
                wr_data_reg <= s_data;
                if (j_reg == J_LAST) begin
                    j_reg <= '0;
                    i_reg <= (i_reg == I_LAST) ? '0 : i_reg + I_ONE;
                end else begin
                    j_reg <= j_reg + J_ONE;
                end
            end
        end
    end

`ifdef MEM_BANK_LOADER_CSUM_EN
    logic [DW-1:0] sum_reg;
    logic          csum_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg      <= '0;
            csum_err_reg <= 1'b0;
        end else if (start_ok) begin
            sum_reg      <= '0;
            csum_err_reg <= 1'b0;
        end else if (load_xfer) begin
            sum_reg <= sum_reg + s_data;
        end else if ((state_reg == CSUM) && s_valid && !abort) begin
            csum_err_reg <= (s_data != sum_reg);
        end
    end

    assign csum_err = csum_err_reg;
    assign busy     = (state_reg == LOAD) || (state_reg == CSUM);
`else
    assign csum_err = 1'b0;
    assign busy     = (state_reg == LOAD);
`endif

    assign done    = (state_reg == DONE);
    assign wr_en   = wr_en_reg;
    assign addr_i  = addr_i_reg;
    assign addr_j  = addr_j_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_mem_bank_loader.sv
// Directed bench for mem_bank_loader: expected bank writes are queued when a byte is accepted and
// checked by a monitor when wr_en appears; frame-level status is checked inline.
module tb_mem_bank_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, s_valid, bank_rdy;
    logic [7:0] s_data;
    logic       s_ready, wr_en, busy, done, csum_err;
    logic [1:0] addr_i, addr_j;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    mem_bank_loader #(.DW(8), .ROWS(4), .COLS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .bank_rdy (bank_rdy),
        .wr_en    (wr_en),
        .addr_i   (addr_i),
        .addr_j   (addr_j),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .csum_err (csum_err)
    );

    typedef struct {
        int         i;
        int         j;
        logic [7:0] d;
        int         cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  errors   = 0;
    int  checks   = 0;
    int  cyc      = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every wr_en must match the oldest queued transfer, one cycle after it.
    always @(negedge clk) begin
        if (wr_en) begin
            $display("wr  cyc=%0d i=%0d j=%0d data=%02h", cyc, addr_i, addr_j, wr_data);
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr_i", 32'(addr_i), 32'(mon_e.i));
                chk("wr_addr_j", 32'(addr_j), 32'(mon_e.j));
                chk("wr_data",   32'(wr_data), 32'(mon_e.d));
                chk("wr_latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (done) begin
            done_cnt++;
            $display("done cyc=%0d csum_err=%0b", cyc, csum_err);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; k is the cell index it is expected to land in (row-major, 3 columns).
    task automatic send(input logic [7:0] d, input bit expect_wr, input int k);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("s_ready_wait", 32'(s_ready), 32'd1);
        if (s_ready && expect_wr) sb.push_back('{k / 3, k % 3, d, cyc + 1});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] base, input int from, input int to);
        for (int k = from; k < to; k++) send(base + 8'(k), 1'b1, k);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input logic [7:0] trailer, input logic exp_err);
`ifdef MEM_BANK_LOADER_CSUM_EN
        chk("busy_csum", 32'(busy), 32'd1);
        chk("s_ready_csum", 32'(s_ready), 32'd1);
        send(trailer, 1'b0, 0);
        chk("csum_err_done", 32'(csum_err), 32'(exp_err));
`else
        chk("csum_err_tied", 32'(csum_err), 32'(1'b0 & exp_err & trailer[0]));
`endif
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("s_ready_idle", 32'(s_ready), 32'd0);
`ifdef MEM_BANK_LOADER_CSUM_EN
        chk("csum_err_held", 32'(csum_err), 32'(exp_err));
`endif
    endtask

    task automatic check_zero(input string p);
        chk({p, "_s_ready"},  32'(s_ready),  32'd0);
        chk({p, "_wr_en"},    32'(wr_en),    32'd0);
        chk({p, "_addr_i"},   32'(addr_i),   32'd0);
        chk({p, "_addr_j"},   32'(addr_j),   32'd0);
        chk({p, "_wr_data"},  32'(wr_data),  32'd0);
        chk({p, "_busy"},     32'(busy),     32'd0);
        chk({p, "_done"},     32'(done),     32'd0);
        chk({p, "_csum_err"}, 32'(csum_err), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        bank_rdy = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Frame 1: 0x01..0x0C, continuous stream; sum is 0x4E.
        pulse_start();
        chk("busy_load", 32'(busy), 32'd1);
        load_bytes(8'h01, 0, 12);
        finish_frame(8'h4E, 1'b0);

        // Frame 2: bank stalls for 3 cycles after byte 5 with data pending; bad trailer.
        pulse_start();
        load_bytes(8'h01, 0, 5);
        bank_rdy = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'h06;
        repeat (3) begin
            @(negedge clk);
            chk("s_ready_stall", 32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bank_rdy = 1'b1;
        load_bytes(8'h01, 5, 12);
        finish_frame(8'h4F, 1'b1);

        // Frame 3: abort after 7 bytes, with an 8th byte offered in the abort cycle.
        pulse_start();
        chk("csum_err_cleared", 32'(csum_err), 32'd0);
        load_bytes(8'h20, 0, 7);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("busy_after_abort", 32'(busy), 32'd0);
        chk("s_ready_after_abort", 32'(s_ready), 32'd0);
        repeat (4) tick();
        chk("no_done_abort", 32'(done_cnt), 32'd2);

        // Abort wins over start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);
        tick();
        chk("still_idle", 32'(busy), 32'd0);

        // Frame 4: 0xA0..0xAB restarts at (0,0); sum 0xC2.
        pulse_start();
        load_bytes(8'hA0, 0, 12);
        finish_frame(8'hC2, 1'b0);

        // Frame 5: reset pulse after 5 bytes discards the frame.
        pulse_start();
        load_bytes(8'h30, 0, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("midreset");
        repeat (4) tick();
        chk("no_done_reset", 32'(done_cnt), 32'd3);

        // Frame 6: start pulsed mid-frame must not disturb the counters; sum 0x02.
        pulse_start();
        load_bytes(8'h10, 0, 4);
        pulse_start();
        chk("busy_after_restart", 32'(busy), 32'd1);
        load_bytes(8'h10, 4, 12);
        finish_frame(8'h02, 1'b0);

        repeat (3) tick();
        chk("done_total", 32'(done_cnt), 32'd4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
